gyruss_audio_mix: RTL and testbench

- Sequential audio mixer feeding the Gyruss 6 dB/oct anti-alias low-pass stage.
- Each sample period it snapshots NCH unsigned sound-chip channel levels and their per-channel gains.
- It removes each channel's DC offset, scales, accumulates through one shared multiplier, then shifts and saturates.
- Result is a signed 16-bit sample held on out, with a one-cycle out_valid strobe.

---
 rtl/gyruss_audio_mix.sv | 142 ++++++++++++++
 tb/tb_gyruss_audio_mix.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/gyruss_audio_mix.sv
// gyruss_audio_mix: sequential channel mixer feeding the 6 dB/oct anti-alias low-pass stage.
// Once every DIV clocks it snapshots NCH unsigned channel levels and gains, removes each
// channel's midscale offset, scales and accumulates through one shared multiplier, then
// shifts and saturates the sum to a signed 16-bit sample.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high; clears every register
//   ch_in      packed channel levels, channel k at [k*IW +: IW]
//   gain       packed per-channel gains, channel k at [k*GW +: GW]
//   out        signed mixed sample, held between updates
//   out_valid  one-cycle pulse when out updates
//   busy       high while a sample is being accumulated or saturated
module gyruss_audio_mix #(
    parameter int unsigned NCH   = 6,
    parameter int unsigned IW    = 10,
    parameter int unsigned GW    = 8,
    parameter int unsigned SHIFT = 4,
    parameter int unsigned DIV   = 220
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*IW-1:0]    ch_in,
    input  logic [NCH*GW-1:0]    gain,
    output logic signed [15:0]   out,
    output logic                 out_valid,
    output logic                 busy
);

    localparam int unsigned PW = IW + GW + 1;               // signed product width
    localparam int unsigned AW = PW + $clog2(NCH);          // accumulator cannot overflow
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned XW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [IW:0]          Mid    = (IW + 1)'(1 << (IW - 1));
    localparam logic signed [AW-1:0] SatMax = AW'(32767);
    localparam logic signed [AW-1:0] SatMin = AW'(-32768);

    typedef enum logic [1:0] {StIdle, StAcc, StSat} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NCH*IW-1:0]       ch_snap_q, ch_snap_d;
    logic [NCH*GW-1:0]       gain_snap_q, gain_snap_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic [XW-1:0]           idx_q, idx_d;
    logic signed [15:0]      out_q, out_d;
    logic                    out_valid_q, out_valid_d;

    logic                    tick;
    logic [IW-1:0]           ch_sel;
    logic [GW-1:0]           gain_sel;
    logic signed [IW:0]      offset;
    logic signed [PW-1:0]    off_ext, gain_ext, prod;
    logic signed [AW-1:0]    term_ext, shifted;

    assign tick = (cnt_q == CW'(DIV - 1));

    // Shared datapath: one channel term per ACC cycle, selected by idx_q.
    always_comb begin
        ch_sel   = ch_snap_q[int'(idx_q) * IW +: IW];
        gain_sel = gain_snap_q[int'(idx_q) * GW +: GW];
        // Modular IW+1 subtraction yields the correct two's-complement offset.
        offset   = $signed({1'b0, ch_sel} - Mid);
        off_ext  = {{(PW - IW - 1){offset[IW]}}, offset};
        gain_ext = {{(PW - GW){1'b0}}, gain_sel};
        prod     = off_ext * gain_ext;
        term_ext = {{(AW - PW){prod[PW-1]}}, prod};
        shifted  = acc_q >>> SHIFT;
    end

    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        state_d     = state_q;
        ch_snap_d   = ch_snap_q;
        gain_snap_d = gain_snap_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_d       = out_q;
        out_valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (tick) begin
                    ch_snap_d   = ch_in;
                    gain_snap_d = gain;
                    acc_d       = '0;
                    idx_d       = '0;
                    state_d     = StAcc;
                end
            end
            StAcc: begin
                acc_d = acc_q + term_ext;
                if (idx_q == XW'(NCH - 1)) begin
                    idx_d   = '0;
                    state_d = StSat;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StSat: begin
                if (shifted > SatMax) begin
                    out_d = 16'sd32767;
                end else if (shifted < SatMin) begin
                    out_d = -16'sd32768;
                end else begin
                    out_d = shifted[15:0];
                end
                out_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ch_snap_q   <= '0;
            gain_snap_q <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_snap_q   <= ch_snap_d;
            gain_snap_q <= gain_snap_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_gyruss_audio_mix.sv
// Directed bench for gyruss_audio_mix: reset state, first-pulse latency, pulse spacing,
// busy duration, offset/gain arithmetic, floor shift, saturation, snapshot isolation and
// reset during accumulation. Expected values are hand-computed constants.
module tb_gyruss_audio_mix;

    localparam int unsigned NCH   = 6;
    localparam int unsigned IW    = 10;
    localparam int unsigned GW    = 8;
    localparam int unsigned SHIFT = 4;
    localparam int unsigned DIV   = 220;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH*IW-1:0]    ch_in;
    logic [NCH*GW-1:0]    gain;
    logic signed [15:0]   out;
    logic                 out_valid;
    logic                 busy;

    int compared   = 0;
    int mismatched = 0;
    int n, nb;

    always #5 clk = ~clk;

    gyruss_audio_mix #(
        .NCH   (NCH),
        .IW    (IW),
        .GW    (GW),
        .SHIFT (SHIFT),
        .DIV   (DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ch_in     (ch_in),
        .gain      (gain),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // The strobe comes from the SAT->IDLE transition, so busy must already be low.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            check("busy_low_at_pulse", int'(busy), 0);
        end
    end

    task automatic set_mid();
        for (int k = 0; k < int'(NCH); k++) begin
            ch_in[k*IW +: IW] = IW'(512);
            gain[k*GW +: GW]  = '0;
        end
    endtask

    task automatic set_all(input int c, input int g);
        for (int k = 0; k < int'(NCH); k++) begin
            ch_in[k*IW +: IW] = IW'(c);
            gain[k*GW +: GW]  = GW'(g);
        end
    endtask

    task automatic set_ch(input int k, input int c, input int g);
        ch_in[k*IW +: IW] = IW'(c);
        gain[k*GW +: GW]  = GW'(g);
    endtask

    // Edges until out_valid is seen (bounded); also counts cycles with busy high.
    task automatic wait_pulse(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busy_cycles++;
            if (out_valid) break;
        end
    endtask

    task automatic wait_busy(output int edges);
        edges = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) break;
        end
    endtask

    task automatic run_vec(input string tag, input int exp);
        int e, b;
        wait_pulse(e, b);
        check({tag, "_period"}, e, 220);
        check(tag, int'(out), exp);
    endtask

    initial begin
        reset = 1'b1;
        set_all(512, 255);
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", int'(out), 0);
        check("reset_valid", int'(out_valid), 0);
        check("reset_busy", int'(busy), 0);

        reset = 1'b0;
        wait_pulse(n, nb);
        check("first_pulse_latency", n, 227);
        check("midscale_out", int'(out), 0);
        @(posedge clk);
        #1;
        check("valid_one_cycle", int'(out_valid), 0);
        wait_pulse(n, nb);
        check("second_pulse_spacing", n, 219);
        check("busy_cycles", nb, 7);

        set_mid(); set_ch(0, 612, 16);
        run_vec("ch0_plus100", 100);
        set_mid(); set_ch(0, 511, 1);
        run_vec("floor_minus1", -1);
        set_all(1023, 255);
        run_vec("sat_pos", 32767);
        set_all(0, 255);
        run_vec("sat_neg", -32768);
        set_mid(); set_ch(0, 712, 64); set_ch(3, 312, 64);
        run_vec("cancel_zero", 0);
        set_mid(); set_ch(5, 1023, 8); set_ch(2, 0, 8);
        run_vec("mixed_minus1", -1);
        set_mid(); set_ch(1, 1023, 255);
        run_vec("ch1_full", 8144);
        set_mid(); set_ch(4, 500, 3);
        run_vec("floor_minus3", -3);

        // Snapshot isolation: 88*10 = 880, >>>4 = 55, whatever the inputs do during ACC.
        set_mid(); set_ch(1, 600, 10);
        wait_busy(n);
        check("iso_busy_seen", int'(busy), 1);
        repeat (6) begin
            ch_in = 60'({$urandom(), $urandom()});
            gain  = 48'({$urandom(), $urandom()});
            @(posedge clk);
            #1;
        end
        wait_pulse(n, nb);
        check("iso_latency", n, 1);
        check("iso_out", int'(out), 55);

        // Reset during ACC aborts the sample and restarts the divider.
        set_mid(); set_ch(0, 612, 16);
        wait_busy(n);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_out", int'(out), 0);
        check("midreset_valid", int'(out_valid), 0);
        check("midreset_busy", int'(busy), 0);
        reset = 1'b0;
        wait_pulse(n, nb);
        check("midreset_latency", n, 227);
        check("midreset_out_after", int'(out), 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
